// File: rtl/beat_counter_pkg.sv
// rtl/beat_counter_pkg.sv - shared constants for the beat counter tempo path
package beat_counter_pkg;

    localparam int              BCD_W       = 4;
    localparam logic [BCD_W-1:0] BCD_MAX    = 4'd9;
    localparam int              DIV_DEFAULT = 50000;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD digit with enable, synchronous clear and carry-out on 9->0
module bcd_digit
    import beat_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sclr_i,
    output logic [BCD_W-1:0] q_o,
    output logic             co_o
);

    logic [BCD_W-1:0] digit_q, digit_d;

    // >= rather than == so a corrupted digit still returns to 0 instead of walking through A-F
    always_comb begin
        digit_d = digit_q;
        co_o    = 1'b0;
        if (sclr_i) begin
            digit_d = '0;
        end else if (en_i) begin
            if (digit_q >= BCD_MAX) begin
                digit_d = '0;
                co_o    = 1'b1;
            end else begin
                digit_d = digit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q_o = digit_q;

endmodule

// File: rtl/beat_counter.sv
// rtl/beat_counter.sv - prescaled three-digit BCD tick counter with two-digit measure counter
module beat_counter
    import beat_counter_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clr,
    output logic [BCD_W-1:0] cnt2,
    output logic [BCD_W-1:0] cnt1,
    output logic [BCD_W-1:0] cnt0,
    output logic [BCD_W-1:0] meas1,
    output logic [BCD_W-1:0] meas0,
    output logic             tick,
    output logic             bar
);

    localparam int              PW         = $clog2(DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          bar_q, bar_d;
    logic          cnt_inc, cnt_sclr;
    logic          co0, co1, cnt_wrap_unused;
    logic          mco0, meas_wrap_unused;

    // clr only matters on a tick; run low overrides everything and also kills bar
    always_comb begin
        presc_d  = '0;
        tick_d   = 1'b0;
        if (run) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            tick_d  = (presc_q == PRESC_LAST);
        end
        cnt_sclr = !run || (tick_q && clr);
        cnt_inc  = run && tick_q && !clr;
        bar_d    = run && tick_q && clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            bar_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            bar_q   <= bar_d;
        end
    end

    bcd_digit u_cnt0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (cnt_inc),
        .sclr_i (cnt_sclr),
        .q_o    (cnt0),
        .co_o   (co0)
    );

    bcd_digit u_cnt1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (co0),
        .sclr_i (cnt_sclr),
        .q_o    (cnt1),
        .co_o   (co1)
    );

    bcd_digit u_cnt2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (co1),
        .sclr_i (cnt_sclr),
        .q_o    (cnt2),
        .co_o   (cnt_wrap_unused)
    );

    // measure digits step on the same edge that raises bar
    bcd_digit u_meas0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (bar_d),
        .sclr_i (1'b0),
        .q_o    (meas0),
        .co_o   (mco0)
    );

    bcd_digit u_meas1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (mco0),
        .sclr_i (1'b0),
        .q_o    (meas1),
        .co_o   (meas_wrap_unused)
    );

    assign tick = tick_q;
    assign bar  = bar_q;

endmodule
